// File: rtl/lfsr_checker_if.sv
// lfsr_checker port bundle.
// Serial input, clear and status outputs.
interface lfsr_checker_if #(
  parameter int CNT_W = 16
) ();
  logic             in_valid;
  logic             in_bit;
  logic             clr;
  logic             locked;
  logic             err_pulse;
  logic             lost_lock;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output in_valid, in_bit, clr,
    input  locked, err_pulse, lost_lock, err_cnt
  );

  modport slave (
    input  in_valid, in_bit, clr,
    output locked, err_pulse, lost_lock, err_cnt
  );
endinterface

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 8-bit Fibonacci LFSR stream.
// Self-syncs, verifies, locks with a flywheel and counts errors.
module lfsr_checker #(
  parameter int LOCK_LEN    = 16,
  parameter int LOSS_THRESH = 4,
  parameter int CNT_W       = 16
) (
  input  logic           clk,
  input  logic           rst,
  lfsr_checker_if.slave  io
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] LL = 8'(LOCK_LEN);
  localparam logic [3:0] LT = 4'(LOSS_THRESH);

  state_t           state_q, state_d;
  logic [7:0]       r_q, r_d;
  logic [2:0]       fill_q, fill_d;
  logic [7:0]       match_q, match_d;
  logic [3:0]       miss_q, miss_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             locked_q;
  logic             pulse_q;
  logic             lost_q;
  logic             err;
  logic             lost;
  logic             pred;
  logic             hit;

  assign pred = r_q[0] ^ r_q[2] ^ r_q[3] ^ r_q[4];
  assign hit  = (io.in_bit == pred);

  // Next-state, window, counters and pulse decode.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    fill_d  = fill_q;
    match_d = match_q;
    miss_d  = miss_q;
    err     = 1'b0;
    lost    = 1'b0;
    if (io.in_valid) begin
      unique case (state_q)
        HUNT: begin
          r_d    = {io.in_bit, r_q[7:1]};
          fill_d = fill_q + 3'd1;
          if (fill_q == 3'd7) begin
            state_d = VERIFY;
            match_d = 8'd0;
          end
        end
        VERIFY: begin
          r_d = {io.in_bit, r_q[7:1]};
          if (hit && (r_q != 8'd0)) begin
            match_d = match_q + 8'd1;
            if (match_d == LL) begin
              state_d = LOCKED;
              miss_d  = 4'd0;
              match_d = 8'd0;
            end
          end else begin
            match_d = 8'd0;
          end
        end
        LOCKED: begin
          r_d = {pred, r_q[7:1]};
          if (hit) begin
            miss_d = 4'd0;
          end else begin
            err    = 1'b1;
            miss_d = miss_q + 4'd1;
            if (miss_d == LT) begin
              state_d = HUNT;
              fill_d  = 3'd0;
              miss_d  = 4'd0;
              lost    = 1'b1;
            end
          end
        end
        default: begin
          state_d = HUNT;
          fill_d  = 3'd0;
        end
      endcase
    end
  end

  // Saturating error count with a clear that still sees this edge's error.
  always_comb begin
    cnt_d = cnt_q;
    if (io.clr) begin
      cnt_d = CNT_W'(err);
    end else if (err && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Checker state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      r_q     <= 8'd0;
      fill_q  <= 3'd0;
      match_q <= 8'd0;
      miss_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      miss_q  <= miss_d;
    end
  end

  // Registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
      lost_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      locked_q <= (state_d == LOCKED);
      pulse_q  <= err;
      lost_q   <= lost;
      cnt_q    <= cnt_d;
    end
  end

  assign io.locked    = locked_q;
  assign io.err_pulse = pulse_q;
  assign io.lost_lock = lost_q;
  assign io.err_cnt   = cnt_q;

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Serial receive-side checker for the 8-bit Fibonacci LFSR bit stream our display shifter produces. It consumes one bit per accepted cycle and self-synchronises to the sequence by loading the first 8 bits received. It then predicts every following bit, declares lock after a run of correct predictions and counts bit errors while locked. It sits at the far end of a serial link or loopback path and drives status LEDs and the 7-segment error display.

## Interface
- LOCK_LEN, 16: consecutive correct predictions in VERIFY required to enter LOCKED (1..255).
- LOSS_THRESH, 4: consecutive mispredictions in LOCKED that drop lock (1..15).
- CNT_W, 16: width of the error counter.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  in_bit is accepted on this edge.
- in_bit  in  1  received serial bit.
- clr  in  1  synchronous clear of err_cnt.
- locked  out  1  registered; high in LOCKED.
- err_pulse  out  1  registered; one-cycle pulse per mispredicted bit in LOCKED.
- lost_lock  out  1  registered; one-cycle pulse on the LOCKED->HUNT transition.
- err_cnt  out  CNT_W  registered, saturating count of LOCKED mispredictions.

## Operation
- Window register r[7:0] holds the last 8 bits, newest in r[7]. Each shift is r <= {b, r[7:1]}.
- Prediction: pred = r[0]^r[2]^r[3]^r[4]. This matches generator recurrence s[n] = s[n-8]^s[n-6]^s[n-5]^s[n-4], where the generator transmits q[0] and then shifts q <= {q0^q2^q3^q4, q[7:1]}.
- Nothing changes on cycles with in_valid=0; pulses are low on those cycles.
- States:
  - HUNT: shift in_bit into r and increment fill (0..7). On the 8th accepted bit, go to VERIFY with match_cnt=0.
  - VERIFY: shift in_bit into r (self-synchronising).
    - If in_bit==pred and r!=0, increment match_cnt. When the incremented value equals LOCK_LEN, go to LOCKED with miss_cnt=0.
    - On a mismatch, or when r==0 at acceptance, set match_cnt=0 and stay in VERIFY. This stops a stuck-at-0 line from locking.
  - LOCKED (flywheel): shift pred into r, not in_bit, so errors do not propagate. r cannot reach 0 from a nonzero state.
    - On a match, set miss_cnt=0.
    - On a mismatch: err_pulse=1, err_cnt increments with saturation at 2^CNT_W-1, and miss_cnt increments.
    - If miss_cnt reaches LOSS_THRESH: go to HUNT, fill=0, and pulse lost_lock together with err_pulse.
- clr=1: err_cnt is 0 after the edge. If clr coincides with a counted error, err_cnt=1. clr has no effect on state.

## Timing
- Reset values: state=HUNT, r=0, fill=0, match_cnt=0, miss_cnt=0, locked=0, err_pulse=0, lost_lock=0, err_cnt=0. Reset takes effect immediately, including mid-lock.
- All outputs change only on the edge that accepts a bit, or on a clr edge for err_cnt.
- Minimum lock latency: 8+LOCK_LEN accepted bits. locked is high after the edge accepting the last verifying bit (24 for defaults).
- err_pulse and the err_cnt update appear after the edge that accepts the erroneous bit, with no extra delay.
- Loss of lock: locked falls on the same edge where lost_lock pulses. The bit accepted on that edge is not reused for HUNT; fill starts from the next accepted bit.
- Relock after loss: at least 8+LOCK_LEN further accepted bits.

## Test plan
- Generator seeded 0xAA, in_valid=1 continuously: locked rises after the 24th bit, err_cnt stays 0 over 1000 bits, and no pulses occur.
- Locked stream with one bit inverted at bit 100: exactly one err_pulse, err_cnt=1, locked stays high, no further errors.
- Locked stream with 4 consecutive inverted bits: 4 err_pulse, err_cnt=4, lost_lock on the 4th, locked low. Relock exactly 24 clean bits later.
- in_bit stuck at 0 for 200 bits, then stuck at 1 for 200 bits: locked never asserts and err_cnt stays 0.
- Stream with in_valid toggling pseudo-randomly at 50% duty: identical lock point in accepted-bit count, and state unchanged on idle cycles.
- CNT_W=3, 10 isolated errors while locked: err_cnt saturates at 7. Assert clr on the edge of an error: err_cnt=1. Assert rst mid-lock: all outputs 0 immediately, and lock is regained after 24 bits.
